// File: rtl/fir_tap_port_arbiter.sv
// fir_tap_port_arbiter
//   Shares the single-port tap-coefficient BRAM between the AXI-lite
//   configuration path (cfg, read/write) and the FIR MAC engine (eng,
//   read-only).
//   - While no frame runs (ap_busy=0), a tie goes round-robin to the requester
//     that was not granted last.
//   - While a frame runs, the engine has strict priority. cfg reads take only
//     idle engine cycles, and cfg writes wait, so the taps stay frozen for the
//     whole frame.
//   - Each grant issues one BRAM access in the following cycle.
//   - A tag pipeline carries (valid, owner, oor, err) alongside the BRAM read
//     latency, so each read return goes to the requester that issued it.
//
// Ports
//   axis_clk, axis_rst_n           clock, asynchronous active-low reset
//   ap_busy                        frame in progress
//   cfg_req/we/wstrb/addr/wdata    cfg request, held until cfg_gnt
//   cfg_gnt                        cfg request accepted (combinational)
//   cfg_rvalid/rdata               cfg read return (rdata 0 when not valid)
//   cfg_err                        1-cycle pulse for an out-of-range cfg access
//   eng_req/addr                   engine read request, held until eng_gnt
//   eng_gnt                        engine request accepted (combinational)
//   eng_rvalid/rdata               engine read return (rdata 0 when not valid)
//   tap_EN/WE/A/Di/Do              BRAM port (registered controls, read data in)
module fir_tap_port_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int TAP_DEPTH   = 11,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_busy,
  input  logic                   cfg_req,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_wstrb,
  input  logic [pADDR_WIDTH-1:0] cfg_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  output logic                   cfg_gnt,
  output logic                   cfg_rvalid,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  output logic                   cfg_err,
  input  logic                   eng_req,
  input  logic [pADDR_WIDTH-1:0] eng_addr,
  output logic                   eng_gnt,
  output logic                   eng_rvalid,
  output logic [pDATA_WIDTH-1:0] eng_rdata,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam int IDX_W = pADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0]       TAP_LIMIT  = IDX_W'(TAP_DEPTH);
  localparam logic [pADDR_WIDTH-1:0] ALIGN_MASK = {{IDX_W{1'b1}}, 2'b00};
  localparam logic OWNER_CFG = 1'b0;
  localparam logic OWNER_ENG = 1'b1;

  typedef struct packed {
    logic valid;  // a read is in flight in this slot
    logic owner;  // requester that issued it
    logic oor;    // out of range: the BRAM was not enabled, so return zero
    logic err;    // out-of-range cfg access, reported one cycle after grant
  } tag_t;

  logic                   last_gnt;
  logic                   cfg_ok;
  logic                   gnt_cfg;
  logic                   gnt_eng;
  logic                   any_gnt;
  logic                   sel_we;
  logic                   sel_oor;
  logic [pADDR_WIDTH-1:0] sel_addr;
  tag_t                   tag_q [RD_LATENCY+1];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    gnt_cfg  = 1'b0;
    gnt_eng  = 1'b0;
    sel_addr = cfg_addr;
    // During a frame, a cfg write never enters, and a cfg read uses only a
    // cycle the engine leaves idle.
    cfg_ok   = cfg_req && !(ap_busy && (cfg_we || eng_req));
    if (axis_rst_n) begin
      if (eng_req && (ap_busy || !cfg_req || last_gnt == OWNER_CFG)) begin
        gnt_eng  = 1'b1;
        sel_addr = eng_addr;
      end else begin
        gnt_cfg  = cfg_ok;
      end
    end
    any_gnt = gnt_cfg || gnt_eng;
    sel_we  = gnt_cfg && cfg_we;
    sel_oor = sel_addr[pADDR_WIDTH-1:2] >= TAP_LIMIT;
  end

  assign cfg_gnt = gnt_cfg;
  assign eng_gnt = gnt_eng;

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      last_gnt <= OWNER_ENG;   // cfg wins the first tie after reset
      tap_EN   <= 1'b0;
      tap_WE   <= '0;
      tap_A    <= '0;
      tap_Di   <= '0;
    end else begin
      if (any_gnt) begin
        last_gnt <= gnt_eng;
        tap_A    <= sel_addr & ALIGN_MASK;
      end
      if (sel_we) begin
        tap_Di <= cfg_wdata;
      end
      tap_EN <= any_gnt && !sel_oor;
      tap_WE <= (sel_we && !sel_oor) ? cfg_wstrb : 4'b0000;
    end
  end

  // NOTE: the tag pipeline is reset even though it is array-shaped. A
  // stale valid bit left over from before reset would otherwise surface as a
  // spurious rvalid after reset is released.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: any_gnt && !sel_we,
                    owner: gnt_eng,
                    oor:   sel_oor,
                    err:   gnt_cfg && sel_oor};
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Stage 0 lines up with the BRAM enable cycle.
  // Stage RD_LATENCY lines up with valid tap_Do.
  always_comb begin
    cfg_err    = tag_q[0].err;
    cfg_rvalid = tag_q[RD_LATENCY].valid && tag_q[RD_LATENCY].owner == OWNER_CFG;
    eng_rvalid = tag_q[RD_LATENCY].valid && tag_q[RD_LATENCY].owner == OWNER_ENG;
    cfg_rdata  = (cfg_rvalid && !tag_q[RD_LATENCY].oor) ? tap_Do : '0;
    eng_rdata  = (eng_rvalid && !tag_q[RD_LATENCY].oor) ? tap_Do : '0;
  end

endmodule

// File: tb/tb_fir_tap_port_arbiter.sv
// tb_fir_tap_port_arbiter
//   Self-checking bench for fir_tap_port_arbiter.
//   - A behavioural BRAM model drives tap_Do.
//   - A rule-level reference model predicts grants, BRAM controls, errors and
//     read returns. Its shadow copy of the taps is updated at the moment a
//     write is granted.
//   - Stimulus: a table of directed vectors, hand-written multi-cycle
//     sequences, then randomized requesters that follow the hold-until-grant
//     protocol.
module tb_fir_tap_port_arbiter;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 11;
  localparam int LAT   = 1;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          ap_busy = 1'b0;
  logic          cfg_req = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_wstrb = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_gnt, cfg_rvalid, cfg_err;
  logic [DW-1:0] cfg_rdata;
  logic          eng_req = 1'b0;
  logic [AW-1:0] eng_addr = '0;
  logic          eng_gnt, eng_rvalid;
  logic [DW-1:0] eng_rdata;
  logic          tap_EN;
  logic [3:0]    tap_WE;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Di;
  logic [DW-1:0] tap_Do;

  fir_tap_port_arbiter #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .TAP_DEPTH(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .ap_busy(ap_busy),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_wstrb(cfg_wstrb),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_gnt(cfg_gnt),
    .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di),
    .tap_Do(tap_Do)
  );

  always #5 axis_clk = ~axis_clk;

  // Behavioural BRAM: read data appears LAT cycles after the enable cycle.
  logic [DW-1:0] bram [1024];
  logic [DW-1:0] do_pipe [LAT];
  assign tap_Do = do_pipe[LAT-1];

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (tap_WE[b]) bram[tap_A[AW-1:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      end
      do_pipe[0] <= bram[tap_A[AW-1:2]];
    end
    for (int i = 1; i < LAT; i++) do_pipe[i] <= do_pipe[i-1];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] shadow [DEPTH];
  logic          m_last_eng;
  logic          m_gcfg, m_geng;
  logic          e_en, e_err;
  logic [3:0]    e_we;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_di;
  logic          r_v [8][2];  // [cycle mod 8][0=cfg, 1=eng]
  logic [DW-1:0] r_d [8][2];
  int            cyc = 0;

  task automatic model_reset();
    m_last_eng = 1'b1;
    e_en = 0; e_err = 0; e_we = '0; e_a = '0; e_di = '0;
    for (int s = 0; s < 8; s++) begin
      r_v[s][0] = 0; r_v[s][1] = 0; r_d[s][0] = '0; r_d[s][1] = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".cfg_gnt"}, cfg_gnt, 0);
    check({tag, ".eng_gnt"}, eng_gnt, 0);
    check({tag, ".cfg_rvalid"}, cfg_rvalid, 0);
    check({tag, ".cfg_rdata"}, cfg_rdata, 0);
    check({tag, ".cfg_err"}, cfg_err, 0);
    check({tag, ".eng_rvalid"}, eng_rvalid, 0);
    check({tag, ".eng_rdata"}, eng_rdata, 0);
    check({tag, ".tap_EN"}, tap_EN, 0);
    check({tag, ".tap_WE"}, tap_WE, 0);
    check({tag, ".tap_A"}, tap_A, 0);
    check({tag, ".tap_Di"}, tap_Di, 0);
  endtask

  // One clock cycle.
  // - Drive the inputs.
  // - Compare the DUT against the model for this cycle.
  // - Advance the model to the next cycle.
  task automatic step(input logic busy, input logic creq, input logic cwe,
                      input logic [3:0] cstrb, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cdata, input logic ereq,
                      input logic [AW-1:0] eaddr);
    int slot, rslot, word;
    logic oor;
    logic [AW-1:0] ga;
    @(negedge axis_clk);
    ap_busy = busy; cfg_req = creq; cfg_we = cwe; cfg_wstrb = cstrb;
    cfg_addr = caddr; cfg_wdata = cdata; eng_req = ereq; eng_addr = eaddr;
    #1;
    // Arbitration rules
    m_gcfg = 0; m_geng = 0;
    if (busy) begin
      if (ereq) m_geng = 1;
      else if (creq && !cwe) m_gcfg = 1;
    end else if (creq && ereq) begin
      if (m_last_eng) m_gcfg = 1; else m_geng = 1;
    end else if (creq) m_gcfg = 1;
    else if (ereq) m_geng = 1;

    check("cfg_gnt", cfg_gnt, m_gcfg);
    check("eng_gnt", eng_gnt, m_geng);
    check("tap_EN", tap_EN, e_en);
    check("tap_WE", tap_WE, e_we);
    if (e_en) check("tap_A", tap_A, e_a);
    if (e_we != 0) check("tap_Di", tap_Di, e_di);
    check("cfg_err", cfg_err, e_err);
    slot = cyc % 8;
    check("cfg_rvalid", cfg_rvalid, r_v[slot][0]);
    check("cfg_rdata", cfg_rdata, r_v[slot][0] ? r_d[slot][0] : '0);
    check("eng_rvalid", eng_rvalid, r_v[slot][1]);
    check("eng_rdata", eng_rdata, r_v[slot][1] ? r_d[slot][1] : '0);
    r_v[slot][0] = 0; r_v[slot][1] = 0;

    // Expected BRAM port next cycle, and the read return LAT cycles after it
    e_en = 0; e_we = '0; e_err = 0;
    if (m_gcfg || m_geng) begin
      ga   = m_geng ? eaddr : caddr;
      word = int'(ga >> 2);
      oor  = word >= DEPTH;
      e_a  = ga & ~AW'(3);
      e_en = !oor;
      e_err = m_gcfg && oor;
      if (m_gcfg && cwe) begin
        e_di = cdata;
        if (!oor) begin
          e_we = cstrb;
          for (int b = 0; b < 4; b++)
            if (cstrb[b]) shadow[word][8*b +: 8] = cdata[8*b +: 8];
        end
      end else begin
        rslot = (cyc + 1 + LAT) % 8;
        r_v[rslot][int'(m_geng)] = 1;
        r_d[rslot][int'(m_geng)] = oor ? '0 : shadow[word];
      end
      m_last_eng = m_geng;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 4'h0, '0, '0, 0, '0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          busy, creq, cwe;
    logic [3:0]    strb;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic          ereq;
    logic [AW-1:0] eaddr;
    logic          xg_cfg, xg_eng;
  } vec_t;

  vec_t vt [19];

  initial begin
    int cnt, first_c, last_c, bad_gnt;
    logic cp, ep, cwe_r, busy_r;
    logic [3:0] cs_r;
    logic [AW-1:0] ca_r, ea_r;
    logic [DW-1:0] cd_r;

    for (int i = 0; i < 1024; i++) bram[i] = $urandom;
    for (int i = 0; i < DEPTH; i++) shadow[i] = bram[i];
    do_pipe[0] = '0;

    vt[0]  = '{0, 1, 0, 4'h0, 12'h004, 32'h0, 1, 12'h008, 1, 0};
    vt[1]  = '{0, 1, 0, 4'h0, 12'h004, 32'h0, 1, 12'h008, 0, 1};
    vt[2]  = '{0, 1, 0, 4'h0, 12'h004, 32'h0, 1, 12'h008, 1, 0};
    vt[3]  = '{0, 1, 0, 4'h0, 12'h004, 32'h0, 1, 12'h008, 0, 1};
    vt[4]  = '{0, 1, 1, 4'hF, 12'h008, 32'hFFFFFFF6, 0, 12'h000, 1, 0};
    vt[5]  = '{0, 0, 0, 4'h0, 12'h000, 32'h0, 0, 12'h000, 0, 0};
    vt[6]  = '{1, 1, 1, 4'h3, 12'h004, 32'hA5A51234, 1, 12'h00C, 0, 1};
    vt[7]  = '{1, 1, 1, 4'h3, 12'h004, 32'hA5A51234, 0, 12'h000, 0, 0};
    vt[8]  = '{1, 1, 1, 4'h3, 12'h004, 32'hA5A51234, 1, 12'h010, 0, 1};
    vt[9]  = '{0, 1, 1, 4'h3, 12'h004, 32'hA5A51234, 0, 12'h000, 1, 0};
    vt[10] = '{1, 1, 0, 4'h0, 12'h010, 32'h0, 0, 12'h000, 1, 0};
    vt[11] = '{1, 1, 0, 4'h0, 12'h014, 32'h0, 1, 12'h018, 0, 1};
    vt[12] = '{1, 1, 0, 4'h0, 12'h014, 32'h0, 0, 12'h000, 1, 0};
    vt[13] = '{0, 1, 0, 4'h0, 12'h02C, 32'h0, 0, 12'h000, 1, 0};
    vt[14] = '{0, 0, 0, 4'h0, 12'h000, 32'h0, 0, 12'h000, 0, 0};
    vt[15] = '{0, 0, 0, 4'h0, 12'h000, 32'h0, 0, 12'h000, 0, 0};
    vt[16] = '{0, 1, 1, 4'h1, 12'h000, 32'h00000055, 1, 12'h028, 0, 1};
    vt[17] = '{0, 1, 1, 4'h1, 12'h000, 32'h00000055, 1, 12'h028, 1, 0};
    vt[18] = '{0, 0, 0, 4'h0, 12'h000, 32'h0, 0, 12'h000, 0, 0};

    // Reset state, with both requests high to show that grants stay gated
    model_reset();
    cfg_req = 1; eng_req = 1;
    repeat (2) @(negedge axis_clk);
    #1 check_all_zero("reset");
    cfg_req = 0; eng_req = 0;
    @(negedge axis_clk) axis_rst_n = 1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      step(vt[i].busy, vt[i].creq, vt[i].cwe, vt[i].strb, vt[i].caddr,
           vt[i].cdata, vt[i].ereq, vt[i].eaddr);
      check($sformatf("vec%0d.cfg_gnt", i), cfg_gnt, vt[i].xg_cfg);
      check($sformatf("vec%0d.eng_gnt", i), eng_gnt, vt[i].xg_eng);
      if (i == 5) begin
        check("wr08.tap_EN", tap_EN, 1);
        check("wr08.tap_WE", tap_WE, 4'hF);
        check("wr08.tap_A", tap_A, 12'h008);
        check("wr08.tap_Di", tap_Di, 32'hFFFFFFF6);
      end
      if (i == 6 || i == 7) check("wr08.no_rvalid", cfg_rvalid, 0);
      if (i == 14) begin
        check("oor.tap_EN", tap_EN, 0);
        check("oor.cfg_err", cfg_err, 1);
      end
      if (i == 15) begin
        check("oor.cfg_rvalid", cfg_rvalid, 1);
        check("oor.cfg_rdata", cfg_rdata, 0);
      end
    end

    // Engine streams the 11 taps back to back
    cnt = 0; first_c = -1; last_c = -1;
    for (int k = 0; k < 15; k++) begin
      if (k < DEPTH) step(0, 0, 0, 4'h0, '0, '0, 1, AW'(4 * k));
      else step(0, 0, 0, 4'h0, '0, '0, 0, '0);
      if (eng_rvalid) begin
        cnt++;
        if (first_c < 0) first_c = k;
        last_c = k;
      end
    end
    check("stream.count", cnt, DEPTH);
    check("stream.first", first_c, 2);
    check("stream.last", last_c, DEPTH + 1);

    // A cfg write is held off for a whole busy frame, then granted as ap_busy falls
    bad_gnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 1, 4'hF, 12'h00C, 32'h0BADF00D, 1, AW'(4 * (k % DEPTH)));
      if (cfg_gnt) bad_gnt++;
    end
    check("busy.cfg_gnt_count", bad_gnt, 0);
    step(0, 1, 1, 4'hF, 12'h00C, 32'h0BADF00D, 0, '0);
    check("busy_fall.cfg_gnt", cfg_gnt, 1);
    idle(3);

    // Reset lands while an engine read is in flight
    step(0, 0, 0, 4'h0, '0, '0, 1, 12'h014);
    @(negedge axis_clk);
    axis_rst_n = 0; eng_req = 1; cfg_req = 1;
    #1 check_all_zero("midrst");
    model_reset();
    cfg_req = 0; eng_req = 0;
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      if (eng_rvalid || cfg_rvalid) cnt++;
    end
    check("midrst.no_rvalid", cnt, 0);

    // Randomized requesters holding their fields until granted
    cp = 0; ep = 0; busy_r = 0;
    cwe_r = 0; cs_r = '0; ca_r = '0; cd_r = '0; ea_r = '0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) busy_r = !busy_r;
      if (!cp && $urandom_range(0, 2) == 0) begin
        cp = 1; cwe_r = 1'($urandom_range(0, 1)); cs_r = 4'($urandom);
        ca_r = AW'(($urandom_range(0, 13) << 2) | $urandom_range(0, 3));
        cd_r = $urandom;
      end
      if (!ep && $urandom_range(0, 1) == 0) begin
        ep = 1;
        ea_r = AW'(($urandom_range(0, 12) << 2) | $urandom_range(0, 3));
      end
      step(busy_r, cp, cwe_r, cs_r, ca_r, cd_r, ep, ea_r);
      if (m_gcfg) cp = 0;
      if (m_geng) ep = 0;
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
